// File: rtl/noc_pkg.sv
// Shared constants and state encoding for the NoC merge-node blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package noc_pkg;

  localparam int N_PORTS_DEF   = 4;
  localparam int LOG_N_DEF     = 2;
  localparam int BURST_MAX_DEF = 4;
  localparam int LOG_B_DEF     = 3;

  // IDLE: nothing popped last cycle; GRANT: owner was popped last cycle.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit after base, wrapping to base itself last.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick
  import noc_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int LOG_N   = LOG_N_DEF
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [LOG_N-1:0]   base,
  output logic               found,
  output logic [LOG_N-1:0]   idx
);

  logic [LOG_N-1:0] pos;

  // Scan from the farthest offset down to the nearest so the nearest hit wins.
  // Offset N_PORTS wraps onto base, giving it the lowest priority.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      pos = base + LOG_N'(k);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/noc_rr_sched.sv
// Round-robin FIFO pop scheduler for one merge node, bursts capped at BURST_MAX.
// Latency: rd combinational in cycle t; sel/out_valid registered, valid in t+1.
// Backpressure: busy suppresses rd; owner/cnt/state hold so a burst resumes intact.
module noc_rr_sched
  import noc_pkg::*;
#(
  parameter int N_PORTS   = N_PORTS_DEF,
  parameter int LOG_N     = LOG_N_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int LOG_B     = LOG_B_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] empty,
  input  logic               busy,
  output logic [N_PORTS-1:0] rd,
  output logic [LOG_N-1:0]   sel,
  output logic               out_valid,
  output logic               idle
);

  localparam logic [LOG_B-1:0] BURST_LIM = LOG_B'(BURST_MAX);
  localparam logic [LOG_N-1:0] OWNER_RST = LOG_N'(N_PORTS - 1);

  sched_state_e     state_q, state_d;
  logic [LOG_N-1:0] owner_q, owner_d;
  logic [LOG_B-1:0] cnt_q, cnt_d;
  logic [LOG_N-1:0] sel_q, sel_d;
  logic             vld_q, vld_d;

  logic [N_PORTS-1:0] req;
  logic               pick_found;
  logic [LOG_N-1:0]   pick_idx;
  logic               keep;
  logic [LOG_N-1:0]   cand;
  logic               pop;

  assign req = ~empty;

  rr_pick #(
    .N_PORTS (N_PORTS),
    .LOG_N   (LOG_N)
  ) u_pick (
    .req   (req),
    .base  (owner_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Stay on the owner while its burst is live; otherwise take the rotate pick.
  // A lone owner that hit the cap comes back through the rotate path, which restarts cnt.
  assign keep = (state_q == ST_GRANT) && req[owner_q] && (cnt_q < BURST_LIM);
  assign cand = keep ? owner_q : pick_idx;
  assign pop  = pick_found && !busy && !rst;

  // One-hot consume strobe for the chosen FIFO.
  always_comb begin
    rd = '0;
    if (pop) rd[cand] = 1'b1;
  end

  // Next-state: a pop moves ownership; an idle non-busy cycle drops to IDLE; busy freezes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    vld_d   = 1'b0;
    if (pop) begin
      state_d = ST_GRANT;
      owner_d = cand;
      sel_d   = cand;
      vld_d   = 1'b1;
      cnt_d   = keep ? cnt_q + LOG_B'(1) : LOG_B'(1);
    end else if (!busy) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_RST;
      cnt_q   <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = vld_q;
  assign idle      = (state_q == ST_IDLE);

endmodule
